// File: rtl/prefetch_unit.sv
// Instruction prefetch stage: issues in-order word fetches, buffers {pc,inst} pairs in a
// show-ahead FIFO for the DPU, and redirects on flush while discarding stale responses.
module prefetch_unit #(
   parameter int unsigned          INST_WIDTH = 32,
   parameter int unsigned          PC_WIDTH   = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
   parameter int unsigned          FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   output logic                  pfu2mem_req_o,
   output logic [PC_WIDTH-1:0]   pfu2mem_addr_o,
   input  logic                  mem2pfu_gnt_i,
   input  logic                  mem2pfu_rvalid_i,
   input  logic [INST_WIDTH-1:0] mem2pfu_rdata_i,
   output logic                  pfu2dpu_valid_o,
   output logic [INST_WIDTH-1:0] pfu2dpu_inst_o,
   output logic [PC_WIDTH-1:0]   pfu2dpu_pc_o,
   input  logic                  dpu2pfu_ready_i,
   input  logic                  ctrl2pfu_flush_i,
   input  logic [PC_WIDTH-1:0]   ctrl2pfu_flush_pc_i,
   input  logic                  ctrl2pfu_stall_i
);

   localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned       CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0]  ONE_C     = 1;
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W:0]    DEPTH_SUM = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  ONE_P     = 1;

   logic                  r_started;
   logic                  r_reqPending;
   logic [PC_WIDTH-1:0]   r_fetchPc;
   logic [CNT_W-1:0]      r_outstanding;
   logic [CNT_W-1:0]      r_discard;
   logic [CNT_W-1:0]      r_count;
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [PTR_W-1:0]      r_pcqWr;
   logic [PTR_W-1:0]      r_pcqRd;
   logic [INST_WIDTH-1:0] r_instMem [FIFO_DEPTH];
   logic [PC_WIDTH-1:0]   r_pcMem   [FIFO_DEPTH];
   logic [PC_WIDTH-1:0]   r_pcqMem  [FIFO_DEPTH];

   logic [CNT_W:0]        w_inFlight;
   logic                  w_req;
   logic                  w_grant;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_valid;
   logic [CNT_W-1:0]      w_outNext;
   logic [PC_WIDTH-1:0]   w_flushPc;

   // Credit covers both buffered entries and in-flight fetches, so the FIFO can never overflow.
   assign w_inFlight = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req      = r_started && !ctrl2pfu_flush_i &&
                       (r_reqPending || (!ctrl2pfu_stall_i && (w_inFlight < DEPTH_SUM)));
   assign w_grant    = w_req && mem2pfu_gnt_i;
   assign w_push     = mem2pfu_rvalid_i && (r_discard == '0) && !ctrl2pfu_flush_i;
   assign w_valid    = (r_count != '0) && !ctrl2pfu_stall_i;
   assign w_pop      = w_valid && dpu2pfu_ready_i && !ctrl2pfu_flush_i;
   assign w_flushPc  = ctrl2pfu_flush_pc_i & ~(PC_WIDTH'(3));

   always_comb begin
      w_outNext = r_outstanding;
      if (w_grant && !mem2pfu_rvalid_i)
         w_outNext = r_outstanding + ONE_C;
      else if (!w_grant && mem2pfu_rvalid_i)
         w_outNext = r_outstanding - ONE_C;
   end

   assign pfu2mem_req_o   = w_req;
   assign pfu2mem_addr_o  = r_fetchPc;
   assign pfu2dpu_valid_o = w_valid;
   assign pfu2dpu_inst_o  = r_instMem[r_rdPtr];
   assign pfu2dpu_pc_o    = r_pcMem[r_rdPtr];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_started     <= 1'b0;
         r_reqPending  <= 1'b0;
         r_fetchPc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_started     <= 1'b1;
         r_reqPending  <= w_req && !mem2pfu_gnt_i;
         r_outstanding <= w_outNext;
         if (ctrl2pfu_flush_i)
            r_fetchPc <= w_flushPc;
         else if (w_grant)
            r_fetchPc <= r_fetchPc + PC_WIDTH'(4);
         // Everything still in flight at a flush belongs to the old stream.
         if (ctrl2pfu_flush_i)
            r_discard <= w_outNext;
         else if (mem2pfu_rvalid_i && (r_discard != '0))
            r_discard <= r_discard - ONE_C;
      end
   end

   // The PC queue pairs each in-order response with the address it was fetched from.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pcqWr <= '0;
         r_pcqRd <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_pcqMem[i] <= '0;
      end else begin
         if (w_grant) begin
            r_pcqMem[r_pcqWr] <= r_fetchPc;
            r_pcqWr           <= r_pcqWr + ONE_P;
         end
         if (mem2pfu_rvalid_i)
            r_pcqRd <= r_pcqRd + ONE_P;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_count <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_instMem[i] <= '0;
            r_pcMem[i]   <= '0;
         end
      end else if (ctrl2pfu_flush_i) begin
         r_count <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_instMem[r_wrPtr] <= mem2pfu_rdata_i;
            r_pcMem[r_wrPtr]   <= r_pcqMem[r_pcqRd];
            r_wrPtr            <= r_wrPtr + ONE_P;
         end
         if (w_pop)
            r_rdPtr <= r_rdPtr + ONE_P;
         if (w_push && !w_pop)
            r_count <= r_count + ONE_C;
         else if (!w_push && w_pop)
            r_count <= r_count - ONE_C;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         assert (!(w_push && !w_pop && (r_count >= DEPTH_CNT)));
         assert (r_outstanding <= DEPTH_CNT);
      end
   end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: a one-cycle-latency memory model feeds the DUT while
// scenario tasks compare the handshake outputs against hand-derived values.
module tb_prefetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        pfu2mem_req_o;
   logic [31:0] pfu2mem_addr_o;
   logic        mem2pfu_gnt_i;
   logic        mem2pfu_rvalid_i;
   logic [31:0] mem2pfu_rdata_i;
   logic        pfu2dpu_valid_o;
   logic [31:0] pfu2dpu_inst_o;
   logic [31:0] pfu2dpu_pc_o;
   logic        dpu2pfu_ready_i;
   logic        ctrl2pfu_flush_i;
   logic [31:0] ctrl2pfu_flush_pc_i;
   logic        ctrl2pfu_stall_i;

   int          vecCount   = 0;
   int          errCount   = 0;
   int          grantCount = 0;
   bit          rspEn      = 1'b1;
   logic [31:0] memQ [$];

   always #5 clk_i = ~clk_i;

   prefetch_unit #(
      .INST_WIDTH (32),
      .PC_WIDTH   (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .pfu2mem_req_o       (pfu2mem_req_o),
      .pfu2mem_addr_o      (pfu2mem_addr_o),
      .mem2pfu_gnt_i       (mem2pfu_gnt_i),
      .mem2pfu_rvalid_i    (mem2pfu_rvalid_i),
      .mem2pfu_rdata_i     (mem2pfu_rdata_i),
      .pfu2dpu_valid_o     (pfu2dpu_valid_o),
      .pfu2dpu_inst_o      (pfu2dpu_inst_o),
      .pfu2dpu_pc_o        (pfu2dpu_pc_o),
      .dpu2pfu_ready_i     (dpu2pfu_ready_i),
      .ctrl2pfu_flush_i    (ctrl2pfu_flush_i),
      .ctrl2pfu_flush_pc_i (ctrl2pfu_flush_pc_i),
      .ctrl2pfu_stall_i    (ctrl2pfu_stall_i)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // One clock: memory model answers each grant in the following cycle; flush is a pulse.
   task automatic step();
      logic        g;
      logic        r;
      logic [31:0] a;
      logic [31:0] dropped;
      #1;
      g = pfu2mem_req_o && mem2pfu_gnt_i;
      r = mem2pfu_rvalid_i;
      a = pfu2mem_addr_o;
      @(posedge clk_i);
      #1;
      if (r && memQ.size() > 0) dropped = memQ.pop_front();
      if (g) begin
         memQ.push_back(a);
         grantCount++;
      end
      ctrl2pfu_flush_i = 1'b0;
      if (rspEn && memQ.size() > 0) begin
         mem2pfu_rvalid_i = 1'b1;
         mem2pfu_rdata_i  = memWord(memQ[0]);
      end else begin
         mem2pfu_rvalid_i = 1'b0;
         mem2pfu_rdata_i  = '0;
      end
      #1;
   endtask

   task automatic doReset();
      rst_n_i             = 1'b0;
      mem2pfu_gnt_i       = 1'b1;
      mem2pfu_rvalid_i    = 1'b0;
      mem2pfu_rdata_i     = '0;
      dpu2pfu_ready_i     = 1'b1;
      ctrl2pfu_flush_i    = 1'b0;
      ctrl2pfu_flush_pc_i = '0;
      ctrl2pfu_stall_i    = 1'b0;
      rspEn               = 1'b1;
      grantCount          = 0;
      memQ.delete();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n_i             = 1'b0;
      mem2pfu_gnt_i       = 1'b1;
      mem2pfu_rvalid_i    = 1'b0;
      mem2pfu_rdata_i     = '0;
      dpu2pfu_ready_i     = 1'b1;
      ctrl2pfu_flush_i    = 1'b0;
      ctrl2pfu_flush_pc_i = '0;
      ctrl2pfu_stall_i    = 1'b0;
      @(posedge clk_i);
      #1;
      vecCount++; if (pfu2mem_req_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset_req: got %0b expected 0", pfu2mem_req_o); end
      vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", pfu2dpu_valid_o); end
      vecCount++; if (pfu2mem_addr_o !== 32'h0) begin errCount++; $display("[TB] FAIL reset_addr: got %h expected 00000000", pfu2mem_addr_o); end
      vecCount++; if (pfu2dpu_inst_o !== 32'h0) begin errCount++; $display("[TB] FAIL reset_inst: got %h expected 00000000", pfu2dpu_inst_o); end
      vecCount++; if (pfu2dpu_pc_o !== 32'h0) begin errCount++; $display("[TB] FAIL reset_pc: got %h expected 00000000", pfu2dpu_pc_o); end
   endtask

   task automatic test_stream();
      doReset();
      for (int c = 0; c < 3; c++) begin
         vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL stream_early_valid c%0d: got %0b expected 0", c, pfu2dpu_valid_o); end
         step();
      end
      for (int i = 0; i < 6; i++) begin
         vecCount++; if (pfu2dpu_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL stream_valid %0d: got %0b expected 1", i, pfu2dpu_valid_o); end
         vecCount++; if (pfu2dpu_pc_o !== 32'(4*i)) begin errCount++; $display("[TB] FAIL stream_pc %0d: got %h expected %h", i, pfu2dpu_pc_o, 32'(4*i)); end
         vecCount++; if (pfu2dpu_inst_o !== memWord(32'(4*i))) begin errCount++; $display("[TB] FAIL stream_inst %0d: got %h expected %h", i, pfu2dpu_inst_o, memWord(32'(4*i))); end
         step();
      end
   endtask

   task automatic test_backpressure();
      doReset();
      dpu2pfu_ready_i = 1'b0;
      for (int c = 0; c < 12; c++) step();
      vecCount++; if (grantCount !== 4) begin errCount++; $display("[TB] FAIL bp_grants: got %0d expected 4", grantCount); end
      vecCount++; if (pfu2mem_req_o !== 1'b0) begin errCount++; $display("[TB] FAIL bp_req: got %0b expected 0", pfu2mem_req_o); end
      vecCount++; if (pfu2dpu_pc_o !== 32'h0) begin errCount++; $display("[TB] FAIL bp_head_pc: got %h expected 00000000", pfu2dpu_pc_o); end
      dpu2pfu_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         vecCount++; if (pfu2dpu_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL bp_drain_valid %0d: got %0b expected 1", i, pfu2dpu_valid_o); end
         vecCount++; if (pfu2dpu_pc_o !== 32'(4*i)) begin errCount++; $display("[TB] FAIL bp_drain_pc %0d: got %h expected %h", i, pfu2dpu_pc_o, 32'(4*i)); end
         step();
      end
   endtask

   task automatic test_flush();
      int          got;
      logic [31:0] exp;
      doReset();
      dpu2pfu_ready_i = 1'b0;
      rspEn           = 1'b0;
      for (int c = 0; c < 5; c++) step();
      rspEn = 1'b1;
      step();
      step();
      rspEn = 1'b0;
      step();
      vecCount++; if (pfu2dpu_pc_o !== 32'h0) begin errCount++; $display("[TB] FAIL flush_pre_head: got %h expected 00000000", pfu2dpu_pc_o); end
      ctrl2pfu_flush_i    = 1'b1;
      ctrl2pfu_flush_pc_i = 32'h0000_1003;
      dpu2pfu_ready_i     = 1'b1;
      rspEn               = 1'b1;
      #1;
      vecCount++; if (pfu2mem_req_o !== 1'b0) begin errCount++; $display("[TB] FAIL flush_cycle_req: got %0b expected 0", pfu2mem_req_o); end
      step();
      vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL flush_next_valid: got %0b expected 0", pfu2dpu_valid_o); end
      vecCount++; if (pfu2mem_addr_o !== 32'h0000_1000) begin errCount++; $display("[TB] FAIL flush_addr: got %h expected 00001000", pfu2mem_addr_o); end
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (pfu2dpu_valid_o) begin
            exp = 32'h0000_1000 + 32'(4*got);
            vecCount++; if (pfu2dpu_pc_o !== exp) begin errCount++; $display("[TB] FAIL flush_pc %0d: got %h expected %h", got, pfu2dpu_pc_o, exp); end
            vecCount++; if (pfu2dpu_inst_o !== memWord(exp)) begin errCount++; $display("[TB] FAIL flush_inst %0d: got %h expected %h", got, pfu2dpu_inst_o, memWord(exp)); end
            got++;
         end
         step();
      end
      vecCount++; if (got !== 2) begin errCount++; $display("[TB] FAIL flush_timeout: got %0d deliveries expected 2", got); end
   endtask

   task automatic test_flush_collide();
      int          got;
      logic [31:0] exp;
      doReset();
      dpu2pfu_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) step();
      vecCount++; if (mem2pfu_rvalid_i !== 1'b1 || pfu2mem_req_o !== 1'b1) begin errCount++; $display("[TB] FAIL collide_setup: got rvalid %0b req %0b expected 1 1", mem2pfu_rvalid_i, pfu2mem_req_o); end
      ctrl2pfu_flush_i    = 1'b1;
      ctrl2pfu_flush_pc_i = 32'h0000_2000;
      dpu2pfu_ready_i     = 1'b1;
      step();
      vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL collide_next_valid: got %0b expected 0", pfu2dpu_valid_o); end
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (pfu2dpu_valid_o) begin
            exp = 32'h0000_2000 + 32'(4*got);
            vecCount++; if (pfu2dpu_pc_o !== exp) begin errCount++; $display("[TB] FAIL collide_pc %0d: got %h expected %h", got, pfu2dpu_pc_o, exp); end
            got++;
         end
         step();
      end
      vecCount++; if (got !== 2) begin errCount++; $display("[TB] FAIL collide_timeout: got %0d deliveries expected 2", got); end
   endtask

   task automatic test_wrap();
      int          got;
      logic [31:0] exp;
      doReset();
      step();
      ctrl2pfu_flush_i    = 1'b1;
      ctrl2pfu_flush_pc_i = 32'hFFFF_FFFE;
      step();
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (pfu2dpu_valid_o) begin
            exp = 32'hFFFF_FFFC + 32'(4*got);
            vecCount++; if (pfu2dpu_pc_o !== exp) begin errCount++; $display("[TB] FAIL wrap_pc %0d: got %h expected %h", got, pfu2dpu_pc_o, exp); end
            vecCount++; if (pfu2dpu_inst_o !== memWord(exp)) begin errCount++; $display("[TB] FAIL wrap_inst %0d: got %h expected %h", got, pfu2dpu_inst_o, memWord(exp)); end
            got++;
         end
         step();
      end
      vecCount++; if (got !== 2) begin errCount++; $display("[TB] FAIL wrap_timeout: got %0d deliveries expected 2", got); end
   endtask

   task automatic test_stall();
      doReset();
      mem2pfu_gnt_i = 1'b0;
      step();
      step();
      ctrl2pfu_stall_i = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         vecCount++; if (pfu2mem_req_o !== 1'b1) begin errCount++; $display("[TB] FAIL stall_hold_req %0d: got %0b expected 1", c, pfu2mem_req_o); end
         vecCount++; if (pfu2mem_addr_o !== 32'h0) begin errCount++; $display("[TB] FAIL stall_hold_addr %0d: got %h expected 00000000", c, pfu2mem_addr_o); end
         step();
      end
      mem2pfu_gnt_i = 1'b1;
      step();
      vecCount++; if (pfu2mem_addr_o !== 32'h4) begin errCount++; $display("[TB] FAIL stall_addr_after_gnt: got %h expected 00000004", pfu2mem_addr_o); end
      for (int c = 0; c < 3; c++) begin
         vecCount++; if (pfu2mem_req_o !== 1'b0) begin errCount++; $display("[TB] FAIL stall_no_req %0d: got %0b expected 0", c, pfu2mem_req_o); end
         vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL stall_valid %0d: got %0b expected 0", c, pfu2dpu_valid_o); end
         step();
      end
      ctrl2pfu_stall_i = 1'b0;
      #1;
      vecCount++; if (pfu2dpu_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL stall_release_valid: got %0b expected 1", pfu2dpu_valid_o); end
      vecCount++; if (pfu2dpu_pc_o !== 32'h0) begin errCount++; $display("[TB] FAIL stall_release_pc: got %h expected 00000000", pfu2dpu_pc_o); end
      vecCount++; if (pfu2dpu_inst_o !== memWord(32'h0)) begin errCount++; $display("[TB] FAIL stall_release_inst: got %h expected %h", pfu2dpu_inst_o, memWord(32'h0)); end
   endtask

   task automatic test_midreset();
      doReset();
      rspEn = 1'b0;
      for (int c = 0; c < 3; c++) step();
      vecCount++; if (grantCount !== 2) begin errCount++; $display("[TB] FAIL midrst_setup_grants: got %0d expected 2", grantCount); end
      rst_n_i = 1'b0;
      #1;
      vecCount++; if (pfu2mem_req_o !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_req: got %0b expected 0", pfu2mem_req_o); end
      vecCount++; if (pfu2mem_addr_o !== 32'h0) begin errCount++; $display("[TB] FAIL midrst_addr: got %h expected 00000000", pfu2mem_addr_o); end
      vecCount++; if (pfu2dpu_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL midrst_valid: got %0b expected 0", pfu2dpu_valid_o); end
      vecCount++; if (pfu2dpu_pc_o !== 32'h0 || pfu2dpu_inst_o !== 32'h0) begin errCount++; $display("[TB] FAIL midrst_head: got pc %h inst %h expected 0 0", pfu2dpu_pc_o, pfu2dpu_inst_o); end
      doReset();
      step();
      vecCount++; if (pfu2mem_req_o !== 1'b1) begin errCount++; $display("[TB] FAIL midrst_restart_req: got %0b expected 1", pfu2mem_req_o); end
      vecCount++; if (pfu2mem_addr_o !== 32'h0) begin errCount++; $display("[TB] FAIL midrst_restart_addr: got %h expected 00000000", pfu2mem_addr_o); end
   endtask

   initial begin
      $display("[TB] prefetch_unit directed bench starting");
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_collide();
      test_wrap();
      test_stall();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
